// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: four-digit time-multiplexed 7-segment driver showing a 16-bit value as hex.
// Latency: Digit_idx moves SYNC_STAGES+1 Clk cycles after a Scan_clk rise; An/Seg/Dp follow one cycle later.
// Backpressure: none; Load always accepted, last Load before a frame boundary wins.
//
// Ports: Clk/Reset (async, active-high); Scan_clk (async scan-rate reference, never a clock);
//        Load/Data_in (stage a new value); Blank (force anodes off); An/Seg/Dp (display pins);
//        Digit_idx (digit being driven); Frame_done (pulse on 3->0 wrap); Pending (value awaiting commit).
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zero digits (digit 0 always shown).

module seg7_scan_mux #(
    parameter int           SYNC_STAGES    = 2,
    parameter bit           AN_ACTIVE_LOW  = 1'b1,
    parameter bit           SEG_ACTIVE_LOW = 1'b1,
    parameter logic [3:0]   DP_MASK        = 4'b0000
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Scan_clk,
    input  logic            Load,
    input  logic [15:0]     Data_in,
    input  logic            Blank,
    output logic [3:0]      An,
    output logic [6:0]      Seg,
    output logic            Dp,
    output logic [1:0]      Digit_idx,
    output logic            Frame_done,
    output logic            Pending
);

    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;

    // Active-high gfedcba patterns for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   active_q, active_d;
    logic [1:0]             idx_q, idx_d;
    logic [15:0]            pend_val_q, pend_val_d;
    logic                   pend_flag_q, pend_flag_d;
    logic [15:0]            disp_q, disp_d;
    logic                   frame_done_q, frame_done_d;
    logic [3:0]             an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;

    logic                   tick;
    logic                   wrap;
    logic                   commit;
    logic [3:0]             nibble;
    logic [3:0]             onehot;
    logic [6:0]             seg_raw;
    logic                   digit_off;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [1:0]             msd;
`endif

    always_comb begin
        // Scan-rate edge detection: shift the async reference in, compare with the previous sample.
        sync_d = {sync_q[SYNC_STAGES-2:0], Scan_clk};
        prev_d = sync_q[SYNC_STAGES-1];
        tick   = sync_q[SYNC_STAGES-1] & ~prev_q;

        // First tick only arms the scan; index starts advancing from the second.
        wrap     = tick & active_q & (idx_q == 2'd3);
        active_d = active_q | tick;
        idx_d    = (tick & active_q) ? idx_q + 2'd1 : idx_q;

        // Commit uses the old staged value even if a Load lands on the same cycle.
        commit       = wrap & pend_flag_q;
        disp_d       = commit ? pend_val_q : disp_q;
        pend_val_d   = Load ? Data_in : pend_val_q;
        pend_flag_d  = Load | (pend_flag_q & ~commit);
        frame_done_d = wrap;

        case (idx_q)
            2'd0:    nibble = disp_q[3:0];
            2'd1:    nibble = disp_q[7:4];
            2'd2:    nibble = disp_q[11:8];
            default: nibble = disp_q[15:12];
        endcase
        onehot  = 4'b0001 << idx_q;
        seg_raw = hex7(nibble);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        msd = 2'd0;
        if (disp_q[7:4]   != 4'h0) msd = 2'd1;
        if (disp_q[11:8]  != 4'h0) msd = 2'd2;
        if (disp_q[15:12] != 4'h0) msd = 2'd3;
        digit_off = (idx_q > msd);
`else
        digit_off = 1'b0;
`endif
        if (digit_off) begin
            seg_raw = 7'h00;
        end

        // Outputs decode the registered index/data, so they lag those by one cycle.
        if (Blank || !active_q) begin
            an_d = AN_OFF;
        end else begin
            an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
        end

        if (!active_q) begin
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
        end else begin
            seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
            dp_d  = DP_MASK[idx_q] ? ~DP_OFF : DP_OFF;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            active_q     <= 1'b0;
            idx_q        <= 2'd0;
            pend_val_q   <= 16'h0000;
            pend_flag_q  <= 1'b0;
            disp_q       <= 16'h0000;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            active_q     <= active_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_flag_q  <= pend_flag_d;
            disp_q       <= disp_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign An         = an_q;
    assign Seg        = seg_q;
    assign Dp         = dp_q;
    assign Digit_idx  = idx_q;
    assign Frame_done = frame_done_q;
    assign Pending    = pend_flag_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Testbench for seg7_scan_mux: bench-side model predicts each scan step, expected
// pin values are queued when the step is driven and popped once the outputs settle.
// Default polarities, SYNC_STAGES = 2, DP lit on digit 2.

module tb_seg7_scan_mux;

    localparam logic [3:0] DPM = 4'b0100;

    logic        Clk;
    logic        Reset;
    logic        Scan_clk;
    logic        Load;
    logic [15:0] Data_in;
    logic        Blank;
    logic [3:0]  An;
    logic [6:0]  Seg;
    logic        Dp;
    logic [1:0]  Digit_idx;
    logic        Frame_done;
    logic        Pending;

    seg7_scan_mux #(
        .SYNC_STAGES    (2),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1),
        .DP_MASK        (DPM)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Scan_clk   (Scan_clk),
        .Load       (Load),
        .Data_in    (Data_in),
        .Blank      (Blank),
        .An         (An),
        .Seg        (Seg),
        .Dp         (Dp),
        .Digit_idx  (Digit_idx),
        .Frame_done (Frame_done),
        .Pending    (Pending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       pend;
        int         fd;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit          m_active;
    logic [1:0]  m_idx;
    logic [15:0] m_disp;
    logic [15:0] m_pval;
    bit          m_pend;

    logic [6:0] hex_tbl [16];
    initial begin
        hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    end

    function automatic exp_t predict(input int fd);
        exp_t e;
        logic [3:0] nib;
        int msd;
        bit off;
        nib = 4'((m_disp >> (4 * int'(m_idx))) & 16'h000F);
        msd = 0;
        for (int i = 0; i < 4; i++) if (((m_disp >> (4 * i)) & 16'h000F) != 0) msd = i;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        off = (int'(m_idx) > msd);
`else
        off = 1'b0;
`endif
        e.an   = (Blank || !m_active) ? 4'hF : ~(4'b0001 << m_idx);
        e.seg  = !m_active ? 7'h7F : (off ? 7'h7F : ~hex_tbl[nib]);
        e.dp   = !m_active ? 1'b1 : ~DPM[m_idx];
        e.idx  = m_idx;
        e.pend = m_pend;
        e.fd   = fd;
        return e;
    endfunction

    task automatic model_tick(output bit wrap);
        wrap = 1'b0;
        if (!m_active) begin
            m_active = 1'b1;
        end else begin
            wrap  = (m_idx == 2'd3);
            m_idx = m_idx + 2'd1;
            if (wrap && m_pend) begin
                m_disp = m_pval;
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_idx    = 2'd0;
        m_disp   = 16'h0000;
        m_pval   = 16'h0000;
        m_pend   = 1'b0;
    endtask

    // One Scan_clk period; optional Load lands on the same Clk edge as the tick.
    task automatic scan_step(input bit do_load, input logic [15:0] val);
        bit   wrap;
        int   fd_cnt;
        exp_t e;
        model_tick(wrap);
        if (do_load) begin
            m_pval = val;
            m_pend = 1'b1;
        end
        sb.push_back(predict(wrap ? 1 : 0));

        fd_cnt = 0;
        repeat (3) begin
            @(negedge Clk);
            fd_cnt += int'(Frame_done);
        end
        Scan_clk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            fd_cnt += int'(Frame_done);
            if (k == 2 && do_load) begin
                Load    = 1'b1;
                Data_in = val;
            end
            if (k == 3) Load = 1'b0;
        end
        Scan_clk = 1'b0;

        e = sb.pop_front();
        n_checks += 6;
        if (An !== e.an) begin
            n_fail++; $display("FAIL step_an: got %h want %h (idx %0d)", An, e.an, e.idx);
        end
        if (Seg !== e.seg) begin
            n_fail++; $display("FAIL step_seg: got %h want %h (idx %0d disp %h)", Seg, e.seg, e.idx, m_disp);
        end
        if (Dp !== e.dp) begin
            n_fail++; $display("FAIL step_dp: got %b want %b (idx %0d)", Dp, e.dp, e.idx);
        end
        if (Digit_idx !== e.idx) begin
            n_fail++; $display("FAIL step_idx: got %0d want %0d", Digit_idx, e.idx);
        end
        if (Pending !== e.pend) begin
            n_fail++; $display("FAIL step_pending: got %b want %b", Pending, e.pend);
        end
        if (fd_cnt != e.fd) begin
            n_fail++; $display("FAIL step_frame_done_cycles: got %0d want %0d", fd_cnt, e.fd);
        end
    endtask

    task automatic load_value(input logic [15:0] v);
        @(negedge Clk);
        Load    = 1'b1;
        Data_in = v;
        @(negedge Clk);
        Load   = 1'b0;
        m_pval = v;
        m_pend = 1'b1;
        n_checks++;
        if (Pending !== 1'b1) begin
            n_fail++; $display("FAIL load_pending: got %b want 1", Pending);
        end
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge Clk);
        n_checks += 5;
        if (An !== 4'hF)       begin n_fail++; $display("FAIL reset_an: got %h want f", An); end
        if (Seg !== 7'h7F)     begin n_fail++; $display("FAIL reset_seg: got %h want 7f", Seg); end
        if (Dp !== 1'b1)       begin n_fail++; $display("FAIL reset_dp: got %b want 1", Dp); end
        if (Pending !== 1'b0)  begin n_fail++; $display("FAIL reset_pending: got %b want 0", Pending); end
        if (Digit_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", Digit_idx); end
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        n_checks++;
        if (An !== 4'hF) begin n_fail++; $display("FAIL pre_tick_blank: got %h want f", An); end
        scan_step(1'b0, 16'h0);   // arming tick: index stays 0
    endtask

    task automatic test_latency();
        logic [1:0] idx0;
        logic [3:0] an0;
        idx0 = m_idx;
        an0  = ~(4'b0001 << m_idx);
        repeat (3) @(negedge Clk);
        Scan_clk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            if (k == 2) begin
                n_checks++;
                if (Digit_idx !== idx0) begin n_fail++; $display("FAIL lat_idx_early: got %0d want %0d", Digit_idx, idx0); end
            end
            if (k == 3) begin
                n_checks += 2;
                if (Digit_idx !== idx0 + 2'd1) begin n_fail++; $display("FAIL lat_idx_3: got %0d want %0d", Digit_idx, idx0 + 2'd1); end
                if (An !== an0) begin n_fail++; $display("FAIL lat_an_early: got %h want %h", An, an0); end
            end
            if (k == 4) begin
                n_checks++;
                if (An !== ~(4'b0001 << (idx0 + 2'd1))) begin
                    n_fail++; $display("FAIL lat_an_4: got %h want %h", An, ~(4'b0001 << (idx0 + 2'd1)));
                end
            end
        end
        Scan_clk = 1'b0;
        m_idx = idx0 + 2'd1;
    endtask

    task automatic test_glitch();
        bit wrap;
        repeat (3) @(negedge Clk);
        Scan_clk = 1'b1;
        @(negedge Clk);
        Scan_clk = 1'b0;
        model_tick(wrap);
        repeat (8) @(negedge Clk);
        n_checks++;
        if (Digit_idx !== m_idx) begin n_fail++; $display("FAIL glitch_one_tick: got %0d want %0d", Digit_idx, m_idx); end
    endtask

    task automatic test_load_display();
        load_value(16'h1234);
        for (int s = 0; s < 8; s++) scan_step(1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        load_value(16'h9999);
        load_value(16'h5555);   // overwrites
        for (int s = 0; s < 4 && m_idx != 2'd3; s++) scan_step(1'b0, 16'h0);
        scan_step(1'b1, 16'hAAAA);  // commit of 5555 coincides with Load of AAAA
        n_checks += 2;
        if (Pending !== 1'b1) begin n_fail++; $display("FAIL collide_pending: got %b want 1", Pending); end
        if (m_disp !== 16'h5555) begin n_fail++; $display("FAIL collide_model_disp: got %h want 5555", m_disp); end
        for (int s = 0; s < 8; s++) scan_step(1'b0, 16'h0);
    endtask

    task automatic test_blank();
        load_value(16'hBEEF);
        @(negedge Clk);
        Blank = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (An !== 4'hF) begin n_fail++; $display("FAIL blank_next_cycle: got %h want f", An); end
        for (int s = 0; s < 8; s++) scan_step(1'b0, 16'h0);
        Blank = 1'b0;
        @(negedge Clk);
        n_checks += 2;
        if (An !== ~(4'b0001 << m_idx)) begin n_fail++; $display("FAIL blank_resume: got %h want %h", An, ~(4'b0001 << m_idx)); end
        if (m_pend || Pending !== 1'b0) begin n_fail++; $display("FAIL blank_commit: got %b want 0", Pending); end
    endtask

    task automatic test_zero();
        load_value(16'h0000);
        for (int s = 0; s < 8; s++) scan_step(1'b0, 16'h0);
        load_value(16'h00A5);
        for (int s = 0; s < 8; s++) scan_step(1'b0, 16'h0);
    endtask

    task automatic test_reset_mid();
        load_value(16'h7777);
        scan_step(1'b0, 16'h0);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        model_reset();
        n_checks += 6;
        if (An !== 4'hF)        begin n_fail++; $display("FAIL rmid_an: got %h want f", An); end
        if (Seg !== 7'h7F)      begin n_fail++; $display("FAIL rmid_seg: got %h want 7f", Seg); end
        if (Dp !== 1'b1)        begin n_fail++; $display("FAIL rmid_dp: got %b want 1", Dp); end
        if (Pending !== 1'b0)   begin n_fail++; $display("FAIL rmid_pending: got %b want 0", Pending); end
        if (Digit_idx !== 2'd0) begin n_fail++; $display("FAIL rmid_idx: got %0d want 0", Digit_idx); end
        if (Frame_done !== 1'b0) begin n_fail++; $display("FAIL rmid_fd: got %b want 0", Frame_done); end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        n_checks++;
        if (An !== 4'hF) begin n_fail++; $display("FAIL rmid_blank_after: got %h want f", An); end
        for (int s = 0; s < 5; s++) scan_step(1'b0, 16'h0);
    endtask

    initial begin
        Reset    = 1'b1;
        Scan_clk = 1'b0;
        Load     = 1'b0;
        Data_in  = 16'h0000;
        Blank    = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_load_display();
        test_back_to_back();
        test_blank();
        test_zero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
